ask_slicer: RTL and testbench
=============================

ASK_SLICER -- requirements
Module: ask_slicer

Interface
REQ-001 Parameter LOG2_WIN, default 10: the reference-estimation window is 2^LOG2_WIN symbols.
REQ-002 Parameter REF_INIT, default 18'sd32768: ref_level value after reset.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = reset.
REQ-005 sym_clk_en  input  1  one-clk-wide symbol strobe from clk_en.
REQ-006 y  input  18  signed 1s17 matched-filter output sample.
REQ-007 sym_out  output  2  decided symbol: 00=-3a, 01=-a, 10=+a, 11=+3a.
REQ-008 sym_valid  output  1  one-clk pulse qualifying sym_out.
REQ-009 ref_level  output  18  signed 1s17 current inner/outer decision threshold.
REQ-010 locked  output  1  high once the first window has completed.
REQ-011 mse, sig_pwr  output  38 each  unsigned window-mean squared error and mean squared decided level (MER build only).
REQ-012 mer_valid  output  1  one-clk pulse when mse and sig_pwr update (MER build only).

Function
REQ-013 The block SHALL capture y into a sample register on every rising edge where sym_clk_en=1, and SHALL ignore y on all other edges.
REQ-014 One clk after a capture, the block SHALL register a decision: y_reg>=ref_level->11; 0<=y_reg<ref_level->10; -ref_level<=y_reg<0->01; y_reg<-ref_level->00.
REQ-015 sym_valid SHALL go high for exactly one clk, in the cycle after the capture, only in state TRACK; sym_out SHALL hold its value between decisions.
REQ-016 On each capture, the block SHALL add |y| to a (18+LOG2_WIN)-bit accumulator, saturating |-131072| to 131071.
REQ-017 A symbol counter SHALL count captures modulo 2^LOG2_WIN.
REQ-018 On the capture that wraps the counter, ref_level SHALL load (accumulator including this sample)>>LOG2_WIN, and the accumulator SHALL restart at zero.
REQ-019 A new ref_level SHALL first apply to the decision of the next capture; the wrapping capture's decision SHALL use the old value.
REQ-020 The state machine SHALL have two states, ACQ and TRACK: reset->ACQ; ACQ->TRACK on the first counter wrap; TRACK SHALL hold until reset.
REQ-021 locked SHALL be 1 exactly in TRACK.
REQ-022 If sym_clk_en is asserted on consecutive clks, every capture SHALL be decided and counted, with no drop.

Reset
REQ-023 While reset=0, all registers SHALL clear asynchronously to these values:
- ref_level=REF_INIT
- sym_out=00
- sym_valid=0
- locked=0
- mer_valid=0
- mse=0
- sig_pwr=0
- accumulator, counter and y_reg = 0
- state ACQ
REQ-024 A reset mid-window SHALL discard the partial window, and the block SHALL reacquire from ACQ.

Configuration
REQ-025 Macro ASK_SLICER_MER_EN SHALL compile in the MER path.
REQ-026 With ASK_SLICER_MER_EN defined, each decision in TRACK SHALL work as follows:
- reconstruct the level L: +-ref_level/2 for inner symbols, +-3*ref_level/2 for outer symbols (arithmetic shift, 20-bit).
- accumulate (y_reg-L)^2 and L^2 at full width.
- at the window wrap, latch both sums >>LOG2_WIN into mse and sig_pwr, and pulse mer_valid for one clk.
REQ-027 Without ASK_SLICER_MER_EN, mse, sig_pwr and mer_valid SHALL be absent from the port list, and no MER logic SHALL be synthesized.

Verification
Bench uses LOG2_WIN=2 and sym_clk_en every 4th clk.
REQ-028 Reset: hold reset=0 -> outputs are at their reset values; release reset -> locked=0 and no sym_valid for the first 4 captures.
REQ-029 Window: feed y = 65536, -65536, 21845, -21845 -> on the 4th capture ref_level=43690 and locked=1; the first sym_valid follows the 5th capture.
REQ-030 Decisions with ref_level=43690: feed 43690, 43689, 0, -1, -43690, -43691 -> sym_out = 11, 10, 10, 01, 01, 00.
REQ-031 Saturation: feed y=-131072 four times -> ref_level=131071, with no accumulator wrap.
REQ-032 Back-to-back: assert sym_clk_en on 3 consecutive clks in TRACK -> 3 consecutive sym_valid pulses.
REQ-033 Mid-window reset: assert reset after 2 captures in TRACK -> locked=0 and ref_level=REF_INIT; a full new window is required to relock.
REQ-034 MER build: feed an ideal window at ref_level=43690 (inner levels exactly +-21845, outer +-65535) -> mer_valid pulses with mse=0.

Source files
------------

// File: rtl/ask_slicer.sv
// ask_slicer: 4-level ASK symbol slicer with a self-adjusting inner/outer
// decision threshold. The threshold is the mean |y| over a window of
// 2^LOG2_WIN captured symbols.
// Optional MER measurement path: define ASK_SLICER_MER_EN to compile it in.
module ask_slicer #(
   parameter int                 LOG2_WIN = 10,
   parameter logic signed [17:0] REF_INIT = 18'sd32768
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               sym_clk_en,
   input  logic signed [17:0] y,
   output logic [1:0]         sym_out,
   output logic               sym_valid,
   output logic signed [17:0] ref_level,
   output logic               locked
`ifdef ASK_SLICER_MER_EN
   ,
   output logic [37:0]        mse,
   output logic [37:0]        sig_pwr,
   output logic               mer_valid
`endif
);

   localparam int ACC_W = 18 + LOG2_WIN;
   localparam logic [LOG2_WIN-1:0] CNT_MAX = '1;

   typedef enum logic {
      ACQ   = 1'b0,
      TRACK = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic signed [17:0]    y_q, y_d;
   logic signed [17:0]    ref_snap_q, ref_snap_d;
   logic signed [17:0]    ref_q, ref_d;
   logic [ACC_W-1:0]      acc_q, acc_d;
   logic [LOG2_WIN-1:0]   cnt_q, cnt_d;
   logic                  dec_pend_q, dec_pend_d;
   logic                  trk_pend_q, trk_pend_d;
   logic [1:0]            sym_out_q, sym_out_d;
   logic                  sym_valid_q, sym_valid_d;

   logic [17:0]           mag;
   logic [ACC_W-1:0]      acc_sum;
   logic                  wrap;
   logic signed [18:0]    y_ext;
   logic signed [18:0]    r_ext;
   logic [1:0]            dec;

   // Saturated magnitude of the incoming sample and the window-wrap condition.
   always_comb begin
      mag = y[17] ? 18'(-y) : 18'(y);
      if (y[17] && (y[16:0] == '0)) begin
         mag = 18'd131071;
      end
      acc_sum = acc_q + {{LOG2_WIN{1'b0}}, mag};
      wrap    = sym_clk_en && (cnt_q == CNT_MAX);
   end

   // Capture path: sample register, threshold snapshot, accumulator, counter.
   always_comb begin
      y_d        = y_q;
      ref_snap_d = ref_snap_q;
      ref_d      = ref_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      dec_pend_d = sym_clk_en;
      trk_pend_d = sym_clk_en && (state_q == TRACK);
      if (sym_clk_en) begin
         y_d        = y;
         ref_snap_d = ref_q;
         cnt_d      = cnt_q + LOG2_WIN'(1);
         if (wrap) begin
            acc_d = '0;
            ref_d = $signed(acc_sum[LOG2_WIN +: 18]);
         end else begin
            acc_d = acc_sum;
         end
      end
   end

   // Acquisition state machine: leave ACQ on the first window wrap, then stay.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ACQ:     if (wrap) state_d = TRACK;
         TRACK:   state_d = TRACK;
         default: state_d = ACQ;
      endcase
   end

   // Slicer: compare the captured sample with the threshold valid at capture.
   always_comb begin
      y_ext = {y_q[17], y_q};
      r_ext = {ref_snap_q[17], ref_snap_q};
      if (y_ext >= r_ext) begin
         dec = 2'b11;
      end else if (!y_q[17]) begin
         dec = 2'b10;
      end else if (y_ext >= -r_ext) begin
         dec = 2'b01;
      end else begin
         dec = 2'b00;
      end
      sym_out_d   = dec_pend_q ? dec : sym_out_q;
      sym_valid_d = trk_pend_q;
   end

   // Main register bank with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACQ;
         y_q         <= '0;
         ref_snap_q  <= REF_INIT;
         ref_q       <= REF_INIT;
         acc_q       <= '0;
         cnt_q       <= '0;
         dec_pend_q  <= 1'b0;
         trk_pend_q  <= 1'b0;
         sym_out_q   <= 2'b00;
         sym_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         y_q         <= y_d;
         ref_snap_q  <= ref_snap_d;
         ref_q       <= ref_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         dec_pend_q  <= dec_pend_d;
         trk_pend_q  <= trk_pend_d;
         sym_out_q   <= sym_out_d;
         sym_valid_q <= sym_valid_d;
      end
   end

   assign sym_out   = sym_out_q;
   assign sym_valid = sym_valid_q;
   assign ref_level = ref_q;
   assign locked    = (state_q == TRACK);

`ifdef ASK_SLICER_MER_EN
   localparam int SQ_W = 42 + LOG2_WIN;

   logic                  wrap_pend_q, wrap_pend_d;
   logic [SQ_W-1:0]       se_sum_q, se_sum_d;
   logic [SQ_W-1:0]       sp_sum_q, sp_sum_d;
   logic [37:0]           mse_q, mse_d;
   logic [37:0]           sig_pwr_q, sig_pwr_d;
   logic                  mer_valid_q, mer_valid_d;

   logic signed [19:0]    ref20;
   logic signed [19:0]    ref20_x3;
   logic signed [19:0]    lvl_in;
   logic signed [19:0]    lvl_out;
   logic signed [19:0]    lvl;
   logic signed [20:0]    err;
   logic signed [41:0]    err_sq;
   logic signed [39:0]    lvl_sq;
   logic [SQ_W-1:0]       se_tot;
   logic [SQ_W-1:0]       sp_tot;

   // Reconstruct the ideal level of the decided symbol and its squared error.
   always_comb begin
      ref20    = {{2{ref_snap_q[17]}}, ref_snap_q};
      ref20_x3 = ref20 + (ref20 <<< 1);
      lvl_in   = ref20 >>> 1;
      lvl_out  = ref20_x3 >>> 1;
      case (dec)
         2'b11:   lvl = lvl_out;
         2'b10:   lvl = lvl_in;
         2'b01:   lvl = -lvl_in;
         default: lvl = -lvl_out;
      endcase
      err    = {{3{y_q[17]}}, y_q} - {lvl[19], lvl};
      err_sq = err * err;
      lvl_sq = lvl * lvl;
      se_tot = se_sum_q + {{(SQ_W-42){1'b0}}, err_sq};
      sp_tot = sp_sum_q + {{(SQ_W-40){1'b0}}, lvl_sq};
   end

   // Window sums of error and level power; latch their means at each wrap.
   always_comb begin
      wrap_pend_d = wrap;
      se_sum_d    = se_sum_q;
      sp_sum_d    = sp_sum_q;
      mse_d       = mse_q;
      sig_pwr_d   = sig_pwr_q;
      mer_valid_d = 1'b0;
      if (trk_pend_q) begin
         if (wrap_pend_q) begin
            mse_d       = se_tot[LOG2_WIN +: 38];
            sig_pwr_d   = sp_tot[LOG2_WIN +: 38];
            mer_valid_d = 1'b1;
            se_sum_d    = '0;
            sp_sum_d    = '0;
         end else begin
            se_sum_d = se_tot;
            sp_sum_d = sp_tot;
         end
      end
   end

   // MER register bank with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrap_pend_q <= 1'b0;
         se_sum_q    <= '0;
         sp_sum_q    <= '0;
         mse_q       <= '0;
         sig_pwr_q   <= '0;
         mer_valid_q <= 1'b0;
      end else begin
         wrap_pend_q <= wrap_pend_d;
         se_sum_q    <= se_sum_d;
         sp_sum_q    <= sp_sum_d;
         mse_q       <= mse_d;
         sig_pwr_q   <= sig_pwr_d;
         mer_valid_q <= mer_valid_d;
      end
   end

   assign mse       = mse_q;
   assign sig_pwr   = sig_pwr_q;
   assign mer_valid = mer_valid_q;
`endif

endmodule

// File: tb/tb_ask_slicer.sv
// tb_ask_slicer: self-checking bench for ask_slicer with LOG2_WIN=2 and one
// symbol strobe every 4th clk. Expected values come from a window-average
// reference model held in the bench.
module tb_ask_slicer;

   localparam int WIN      = 4;
   localparam int REF_INIT = 32768;

   logic               clk = 1'b0;
   logic               reset;
   logic               sym_clk_en;
   logic signed [17:0] y;
   logic [1:0]         sym_out;
   logic               sym_valid;
   logic signed [17:0] ref_level;
   logic               locked;
`ifdef ASK_SLICER_MER_EN
   logic [37:0]        mse;
   logic [37:0]        sig_pwr;
   logic               mer_valid;
   int                 mer_cnt = 0;
   logic [37:0]        last_mse;
   logic [37:0]        last_sig;
`endif

   int checks   = 0;
   int failures = 0;

   int m_ref;
   int m_sum;
   int m_cnt;
   bit m_locked;

   ask_slicer #(.LOG2_WIN(2), .REF_INIT(18'sd32768)) dut (
      .clk        (clk),
      .reset      (reset),
      .sym_clk_en (sym_clk_en),
      .y          (y),
      .sym_out    (sym_out),
      .sym_valid  (sym_valid),
      .ref_level  (ref_level),
      .locked     (locked)
`ifdef ASK_SLICER_MER_EN
      ,
      .mse        (mse),
      .sig_pwr    (sig_pwr),
      .mer_valid  (mer_valid)
`endif
   );

   always #5 clk = ~clk;

`ifdef ASK_SLICER_MER_EN
   always @(negedge clk) begin
      if (mer_valid) begin
         mer_cnt  = mer_cnt + 1;
         last_mse = mse;
         last_sig = sig_pwr;
      end
   end
`endif

   task automatic model_reset();
      m_ref    = REF_INIT;
      m_sum    = 0;
      m_cnt    = 0;
      m_locked = 1'b0;
   endtask

   // Decision rule from the level thresholds, then window-average update.
   task automatic model_capture(input int yv, output int exp_out, output bit exp_valid);
      int magn;
      exp_valid = m_locked;
      if (yv >= m_ref)       exp_out = 3;
      else if (yv >= 0)      exp_out = 2;
      else if (yv >= -m_ref) exp_out = 1;
      else                   exp_out = 0;
      magn = (yv < 0) ? -yv : yv;
      if (magn > 131071) magn = 131071;
      m_sum = m_sum + magn;
      m_cnt = m_cnt + 1;
      if (m_cnt == WIN) begin
         m_ref    = m_sum / WIN;
         m_sum    = 0;
         m_cnt    = 0;
         m_locked = 1'b1;
      end
   endtask

   // One symbol slot of 4 clks: strobe, then observe state, decision, idle.
   task automatic send_sym(input int yv, output logic signed [17:0] ref_obs,
                           output logic lock_obs, output logic valid_obs,
                           output logic [1:0] out_obs, output int extra_valid);
      @(negedge clk);
      y          = 18'(yv);
      sym_clk_en = 1'b1;
      @(negedge clk);
      sym_clk_en  = 1'b0;
      y           = 18'($urandom);
      ref_obs     = ref_level;
      lock_obs    = locked;
      extra_valid = int'(sym_valid);
      @(negedge clk);
      valid_obs = sym_valid;
      out_obs   = sym_out;
      @(negedge clk);
      extra_valid = extra_valid + int'(sym_valid);
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      sym_clk_en = 1'b1;
      y          = 18'sd70000;
      repeat (3) @(negedge clk);
      checks++; if (ref_level !== 18'sd32768) begin failures++; $display("[TB] FAIL reset_ref: got %0d expected 32768", ref_level); end
      checks++; if (sym_out !== 2'b00) begin failures++; $display("[TB] FAIL reset_sym_out: got %b expected 00", sym_out); end
      checks++; if (sym_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_sym_valid: got %b expected 0", sym_valid); end
      checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked: got %b expected 0", locked); end
`ifdef ASK_SLICER_MER_EN
      checks++; if (mer_valid !== 1'b0 || mse !== 38'd0 || sig_pwr !== 38'd0) begin failures++; $display("[TB] FAIL reset_mer: got valid=%b mse=%0d sig=%0d expected 0/0/0", mer_valid, mse, sig_pwr); end
`endif
      sym_clk_en = 1'b0;
      reset      = 1'b1;
      model_reset();
   endtask

   task automatic test_window();
      int ys[4] = '{65536, -65536, 21845, -21845};
      logic signed [17:0] r; logic lk, v; logic [1:0] o; int ex; int eo; bit ev;
      for (int i = 0; i < 4; i++) begin
         model_capture(ys[i], eo, ev);
         send_sym(ys[i], r, lk, v, o, ex);
         checks++; if (v !== 1'b0 || ex != 0) begin failures++; $display("[TB] FAIL window_no_valid[%0d]: got valid=%b extra=%0d expected 0/0", i, v, ex); end
         if (i < 3) begin
            checks++; if (lk !== 1'b0 || r !== 18'sd32768) begin failures++; $display("[TB] FAIL window_acq[%0d]: got locked=%b ref=%0d expected 0/32768", i, lk, r); end
         end else begin
            checks++; if (lk !== 1'b1 || r !== 18'sd43690) begin failures++; $display("[TB] FAIL window_lock: got locked=%b ref=%0d expected 1/43690", lk, r); end
         end
      end
   endtask

   task automatic test_decisions();
      int dv[8] = '{43690, 43689, 0, 87381, -1, -43690, -43691, -87380};
      int de[8] = '{3, 2, 2, 3, 1, 1, 0, 0};
      logic signed [17:0] r; logic lk, v; logic [1:0] o; int ex; int eo; bit ev;
      for (int i = 0; i < 8; i++) begin
         model_capture(dv[i], eo, ev);
         send_sym(dv[i], r, lk, v, o, ex);
         checks++; if (v !== 1'b1 || o !== 2'(de[i]) || ex != 0) begin failures++; $display("[TB] FAIL decision[%0d] y=%0d: got valid=%b sym=%b extra=%0d expected 1/%0d/0", i, dv[i], v, o, ex, de[i]); end
         checks++; if (r !== 18'sd43690) begin failures++; $display("[TB] FAIL decision_ref[%0d]: got %0d expected 43690", i, r); end
      end
   endtask

`ifdef ASK_SLICER_MER_EN
   task automatic test_mer();
      int iv[4] = '{21845, -21845, 65535, -65535};
      int before;
      longint exp_sig;
      logic signed [17:0] r; logic lk, v; logic [1:0] o; int ex; int eo; bit ev;
      before  = mer_cnt;
      exp_sig = (2 * 64'd21845 * 64'd21845 + 2 * 64'd65535 * 64'd65535) / WIN;
      for (int i = 0; i < 4; i++) begin
         model_capture(iv[i], eo, ev);
         send_sym(iv[i], r, lk, v, o, ex);
         checks++; if (v !== 1'b1 || o !== 2'(eo)) begin failures++; $display("[TB] FAIL mer_decision[%0d]: got valid=%b sym=%b expected 1/%0d", i, v, o, eo); end
      end
      checks++; if (mer_cnt != before + 1) begin failures++; $display("[TB] FAIL mer_pulse: got %0d pulses expected 1", mer_cnt - before); end
      checks++; if (last_mse !== 38'd0) begin failures++; $display("[TB] FAIL mer_mse: got %0d expected 0", last_mse); end
      checks++; if (last_sig !== 38'(exp_sig)) begin failures++; $display("[TB] FAIL mer_sig_pwr: got %0d expected %0d", last_sig, exp_sig); end
   endtask
`endif

   task automatic test_saturation();
      logic signed [17:0] r; logic lk, v; logic [1:0] o; int ex; int eo; bit ev;
      for (int i = 0; i < 4; i++) begin
         model_capture(-131072, eo, ev);
         send_sym(-131072, r, lk, v, o, ex);
         checks++; if (v !== 1'b1 || o !== 2'b00) begin failures++; $display("[TB] FAIL sat_decision[%0d]: got valid=%b sym=%b expected 1/00", i, v, o); end
      end
      checks++; if (r !== 18'sd131071) begin failures++; $display("[TB] FAIL sat_ref: got %0d expected 131071", r); end
   endtask

   task automatic test_back_to_back();
      int vals[3]; int eo[3]; bit ev[3];
      logic signed [17:0] exp_ref;
      for (int i = 0; i < 3; i++) begin
         vals[i] = $urandom_range(0, 262143) - 131072;
         model_capture(vals[i], eo[i], ev[i]);
      end
      exp_ref = 18'(m_ref);
      @(negedge clk); y = 18'(vals[0]); sym_clk_en = 1'b1;
      @(negedge clk); y = 18'(vals[1]);
      checks++; if (sym_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_pre: got valid=%b expected 0", sym_valid); end
      @(negedge clk); y = 18'(vals[2]);
      checks++; if (sym_valid !== ev[0] || sym_out !== 2'(eo[0])) begin failures++; $display("[TB] FAIL b2b_0: got valid=%b sym=%b expected %b/%0d", sym_valid, sym_out, ev[0], eo[0]); end
      @(negedge clk); sym_clk_en = 1'b0; y = 18'($urandom);
      checks++; if (sym_valid !== ev[1] || sym_out !== 2'(eo[1])) begin failures++; $display("[TB] FAIL b2b_1: got valid=%b sym=%b expected %b/%0d", sym_valid, sym_out, ev[1], eo[1]); end
      @(negedge clk);
      checks++; if (sym_valid !== ev[2] || sym_out !== 2'(eo[2])) begin failures++; $display("[TB] FAIL b2b_2: got valid=%b sym=%b expected %b/%0d", sym_valid, sym_out, ev[2], eo[2]); end
      checks++; if (ref_level !== exp_ref) begin failures++; $display("[TB] FAIL b2b_ref: got %0d expected %0d", ref_level, exp_ref); end
      @(negedge clk);
      checks++; if (sym_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_post: got valid=%b expected 0", sym_valid); end
   endtask

   task automatic test_random(input int n);
      logic signed [17:0] r; logic lk, v; logic [1:0] o; int ex; int eo; bit ev; int yv;
      logic signed [17:0] exp_ref;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 3))
            0:       yv = m_ref + int'($urandom_range(0, 2)) - 1;
            1:       yv = -m_ref + int'($urandom_range(0, 2)) - 1;
            2:       yv = -131072;
            default: yv = int'($urandom_range(0, 262143)) - 131072;
         endcase
         if (yv > 131071) yv = 131071;
         if (yv < -131072) yv = -131072;
         model_capture(yv, eo, ev);
         exp_ref = 18'(m_ref);
         send_sym(yv, r, lk, v, o, ex);
         checks++; if (r !== exp_ref || lk !== m_locked) begin failures++; $display("[TB] FAIL random_state[%0d]: got ref=%0d locked=%b expected %0d/%b", i, r, lk, exp_ref, m_locked); end
         checks++; if (v !== ev || (ev && o !== 2'(eo)) || ex != 0) begin failures++; $display("[TB] FAIL random_decision[%0d] y=%0d: got valid=%b sym=%b extra=%0d expected %b/%0d/0", i, yv, v, o, ex, ev, eo); end
      end
   endtask

   task automatic test_mid_reset();
      logic signed [17:0] r; logic lk, v; logic [1:0] o; int ex; int eo; bit ev; int yv;
      logic signed [17:0] exp_ref;
      for (int i = 0; i < 2; i++) begin
         yv = int'($urandom_range(0, 262143)) - 131072;
         model_capture(yv, eo, ev);
         send_sym(yv, r, lk, v, o, ex);
         checks++; if (v !== 1'b1 || o !== 2'(eo)) begin failures++; $display("[TB] FAIL midrst_pre[%0d]: got valid=%b sym=%b expected 1/%0d", i, v, o, eo); end
      end
      @(negedge clk); reset = 1'b0;
      #1;
      checks++; if (locked !== 1'b0 || ref_level !== 18'sd32768 || sym_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_async: got locked=%b ref=%0d valid=%b expected 0/32768/0", locked, ref_level, sym_valid); end
      @(negedge clk); reset = 1'b1;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         yv = int'($urandom_range(0, 262143)) - 131072;
         model_capture(yv, eo, ev);
         exp_ref = 18'(m_ref);
         send_sym(yv, r, lk, v, o, ex);
         checks++; if (lk !== (i >= 3) || r !== exp_ref) begin failures++; $display("[TB] FAIL midrst_relock[%0d]: got locked=%b ref=%0d expected %b/%0d", i, lk, r, (i >= 3), exp_ref); end
         checks++; if (v !== (i == 4)) begin failures++; $display("[TB] FAIL midrst_valid[%0d]: got %b expected %b", i, v, (i == 4)); end
      end
   endtask

   initial begin
      sym_clk_en = 1'b0;
      y          = '0;
      test_reset();
      test_window();
      test_decisions();
`ifdef ASK_SLICER_MER_EN
      test_mer();
`endif
      test_saturation();
      test_back_to_back();
      test_random(48);
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
